// File: rtl/freq_gate_meas.sv
// Gated edge-count frequency measurement: counts synchronised rising edges of
// sig_in over a GATE_CYCLES window, then holds the count until acknowledged.
module freq_gate_meas #(
    parameter int GATE_CYCLES = 1000,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             start,
    input  logic             ack,
    output logic             busy,
    output logic             valid,
    output logic [CNT_W-1:0] result,
    output logic             ovf
);

    localparam int TW = $clog2(GATE_CYCLES);
    localparam logic [TW-1:0] T_LOAD = TW'(GATE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GATE,
        S_HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       sync_q, sync_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flag_q, flag_d;
    logic [CNT_W-1:0] result_q, result_d;
    logic             ovf_q, ovf_d;

    logic             edge_p;
    logic [CNT_W-1:0] cnt_nxt;
    logic             flag_nxt;

    // sync_q[0..1] form the synchroniser, sync_q[2] is the history flop;
    // it runs in every state so gate opening never sees a stale level.
    assign sync_d = {sync_q[1:0], sig_in};
    assign edge_p = sync_q[1] & ~sync_q[2];

    always_comb begin
        cnt_nxt  = cnt_q;
        flag_nxt = flag_q;
        if (edge_p) begin
            if (&cnt_q) flag_nxt = 1'b1;
            else        cnt_nxt  = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        cnt_d    = cnt_q;
        flag_d   = flag_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_GATE;
                    timer_d = T_LOAD;
                    cnt_d   = '0;
                    flag_d  = 1'b0;
                end
            end
            S_GATE: begin
                cnt_d  = cnt_nxt;
                flag_d = flag_nxt;
                if (timer_q == '0) begin
                    result_d = cnt_nxt;
                    ovf_d    = flag_nxt;
                    state_d  = S_HOLD;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_HOLD: begin
                if (ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            sync_q   <= '0;
            timer_q  <= '0;
            cnt_q    <= '0;
            flag_q   <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            timer_q  <= timer_d;
            cnt_q    <= cnt_d;
            flag_q   <= flag_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy   = (state_q == S_GATE);
    assign valid  = (state_q == S_HOLD);
    assign result = result_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_freq_gate_meas.sv
// Directed bench for freq_gate_meas: a 16-bit instance for the main flow and
// a 4-bit instance for saturation, results checked through queues.
module tb_freq_gate_meas;

    localparam int GATE = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        sig_in;
    logic        start_a, ack_a, start_b, ack_b;
    logic        busy_a, valid_a, ovf_a;
    logic [15:0] result_a;
    logic        busy_b, valid_b, ovf_b;
    logic [3:0]  result_b;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    int   per = 10;
    logic lvl = 1'b0;
    int   ph  = 0;

    logic [16:0] qa[$];
    logic [4:0]  qb[$];

    freq_gate_meas #(.GATE_CYCLES(GATE), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .sig_in(sig_in), .start(start_a), .ack(ack_a),
        .busy(busy_a), .valid(valid_a), .result(result_a), .ovf(ovf_a)
    );

    freq_gate_meas #(.GATE_CYCLES(GATE), .CNT_W(4)) u_b (
        .clk(clk), .rst(rst), .sig_in(sig_in), .start(start_b), .ack(ack_b),
        .busy(busy_b), .valid(valid_b), .result(result_b), .ovf(ovf_b)
    );

    always #5 clk = ~clk;

    // Signal source changes 3 time units after each rising clk edge.
    initial begin
        sig_in = 1'b0;
        forever begin
            @(posedge clk);
            #3;
            if (per == 0) begin
                sig_in = lvl;
            end else begin
                ph     = (ph + 1) % per;
                sig_in = (ph < per / 2);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    int   bcnt = 0;
    logic busy_prev = 1'b0, valid_prev = 1'b0, valid_b_prev = 1'b0;

    always @(negedge clk) begin
        logic [16:0] ea;
        logic [4:0]  eb;
        if (busy_a && !busy_prev) bcnt = 0;
        if (busy_a) bcnt++;
        if (valid_a && !valid_prev) begin
            if (qa.size() == 0) begin
                chk("sb_a_empty", 32'd1, 32'd0);
            end else begin
                ea = qa.pop_front();
                chk("result_a", 32'(result_a), 32'(ea[15:0]));
                chk("ovf_a", 32'(ovf_a), 32'(ea[16]));
                chk("busy_len_a", bcnt, GATE);
            end
        end
        if (valid_b && !valid_b_prev) begin
            if (qb.size() == 0) begin
                chk("sb_b_empty", 32'd1, 32'd0);
            end else begin
                eb = qb.pop_front();
                chk("result_b", 32'(result_b), 32'(eb[3:0]));
                chk("ovf_b", 32'(ovf_b), 32'(eb[4]));
            end
        end
        busy_prev    = busy_a;
        valid_prev   = valid_a;
        valid_b_prev = valid_b;
    end

    task automatic meas_a(input logic [15:0] r, input logic o);
        int n;
        qa.push_back({o, r});
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        n = 1;
        while (!valid_a && n < 2 * GATE) begin
            @(negedge clk);
            n++;
        end
        chk("latency_a", n, GATE + 1);
    endtask

    task automatic ack_a_now();
        ack_a = 1'b1;
        @(negedge clk);
        ack_a = 1'b0;
        chk("ack_valid_low_a", 32'(valid_a), 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b0;
        start_a = 1'b0; ack_a = 1'b0;
        start_b = 1'b0; ack_b = 1'b0;

        // Reset held with activity on the inputs
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start_a = (i % 4 == 1);
            start_b = (i % 4 == 1);
            chk("rst_out_a", {busy_a, valid_a, ovf_a, result_a}, 32'd0);
            chk("rst_out_b", {busy_b, valid_b, ovf_b, result_b}, 32'd0);
        end
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_after_rst_a", {busy_a, valid_a}, 32'd0);
        chk("idle_after_rst_b", {busy_b, valid_b}, 32'd0);

        // Nominal 10-clk period
        per = 10;
        repeat (20) @(negedge clk);
        meas_a(16'd100, 1'b0);
        ack_a_now();

        // No edges: input held high
        per = 0; lvl = 1'b1;
        repeat (20) @(negedge clk);
        meas_a(16'd0, 1'b0);
        ack_a_now();

        // Saturation on the 4-bit instance
        per = 2;
        repeat (5) @(negedge clk);
        qb.push_back({1'b1, 4'hf});
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        n = 1;
        while (!valid_b && n < 2 * GATE) begin
            @(negedge clk);
            n++;
        end
        chk("latency_b", n, GATE + 1);
        ack_b = 1'b1;
        @(negedge clk);
        ack_b = 1'b0;
        chk("ack_valid_low_b", 32'(valid_b), 32'd0);

        // Handshake: withheld ack, ignored starts
        per = 10;
        repeat (5) @(negedge clk);
        meas_a(16'd100, 1'b0);
        for (int i = 0; i < 50; i++) begin
            start_a = (i == 10 || i == 30);
            @(negedge clk);
            if (i % 10 == 1)
                chk("hold_state_a", {busy_a, valid_a, result_a}, {1'b0, 1'b1, 16'd100});
        end
        start_a = 1'b0;
        ack_a_now();
        chk("result_retained_a", 32'(result_a), 32'd100);
        ack_a = 1'b1;
        @(negedge clk);
        ack_a = 1'b0;
        chk("ack_in_idle_a", {busy_a, valid_a}, 32'd0);
        meas_a(16'd100, 1'b0);
        start_a = 1'b1; ack_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; ack_a = 1'b0;
        chk("start_ack_valid_a", 32'(valid_a), 32'd0);
        repeat (5) @(negedge clk);
        chk("start_ack_no_gate_a", 32'(busy_a), 32'd0);

        // Reset in the middle of a gate window
        qa.push_back({1'b0, 16'd100});
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (499) @(negedge clk);
        chk("mid_gate_busy_a", 32'(busy_a), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("async_clear_a", {busy_a, valid_a, ovf_a, result_a}, 32'd0);
        qa.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_after_mid_rst_a", {busy_a, valid_a}, 32'd0);
        meas_a(16'd100, 1'b0);
        ack_a_now();

        repeat (3) @(negedge clk);
        chk("sb_a_drained", qa.size(), 32'd0);
        chk("sb_b_drained", qb.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d", passed, total);
        $fatal(1, "watchdog");
    end

endmodule
